// File: rtl/l2_prefetch_unit.sv
// Next-line prefetcher for the L2: snoops demand fills, fetches the following
// line on its own pmem port and offers it to the L2 from a one-entry buffer.
module l2_prefetch_unit #(
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         l2_pmem_read,
  input  logic         l2_pmem_write,
  input  logic         l2_pmem_resp,
  input  logic [15:0]  l2_pmem_address,
  input  logic         dont_prefetch,
  output logic         prefetch_ready,
  output logic         prefetch_busy,
  output logic [15:0]  prefetch_address,
  output logic [127:0] prefetch_rdata,
  output logic         pf_pmem_read,
  output logic [15:0]  pf_pmem_address,
  input  logic         pf_pmem_resp,
  input  logic [127:0] pf_pmem_rdata
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                pend_valid, pend_valid_n;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   line_data, line_data_n;
  logic                stale, stale_n;

  logic [LINE_W-1:0]   snoop_line;
  logic [LINE_W-1:0]   tgt_line;
  logic [ADDR_W-1:0]   tgt_addr;
  logic                trig, trig_ok, inv, inv_pend, inv_cur, pend_eff, issue;

  // Snoop decode: trigger target, invalidate matches, trigger filtering
  always_comb begin
    snoop_line = l2_pmem_address[ADDR_W-1:OFFSET_BITS];
    tgt_line   = LINE_W'(snoop_line + LINE_W'(1));
    tgt_addr   = {tgt_line, {OFFSET_BITS{1'b0}}};
    trig       = l2_pmem_read & l2_pmem_resp & ~(&snoop_line);
    inv        = l2_pmem_write & l2_pmem_resp;
    inv_pend   = inv & pend_valid & (snoop_line == pend_addr[ADDR_W-1:OFFSET_BITS]);
    inv_cur    = inv & (state != IDLE) & (snoop_line == addr_q[ADDR_W-1:OFFSET_BITS]);
    // The snooped bus carries one address, so W == T can only arise via aliasing;
    // the invalidate still takes priority if it ever does.
    trig_ok    = trig
               & ~((state != IDLE) && (tgt_line == addr_q[ADDR_W-1:OFFSET_BITS]))
               & ~(inv && (snoop_line == tgt_line));
    pend_eff   = pend_valid & ~inv_pend;
  end

  // Next-state and datapath update
  always_comb begin
    state_n      = state;
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    addr_n       = addr_q;
    line_data_n  = line_data;
    stale_n      = stale;
    issue        = 1'b0;

    case (state)
      IDLE: begin
        if (pend_eff && !dont_prefetch) begin
          issue = 1'b1;
        end
      end
      FETCH: begin
        stale_n = stale | inv_cur;
        if (pf_pmem_resp) begin
          if (stale | inv_cur) begin
            state_n = IDLE;
          end else begin
            state_n     = READY;
            line_data_n = pf_pmem_rdata;
          end
        end
      end
      READY: begin
        if (inv_cur) begin
          state_n = IDLE;
        end else if (!dont_prefetch) begin
          if (pend_eff) begin
            issue = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (issue) begin
      state_n = FETCH;
      addr_n  = pend_addr;
      stale_n = 1'b0;
    end

    // Newest trigger always lands in pending, even on the issue cycle
    if (inv_pend || issue) begin
      pend_valid_n = 1'b0;
    end
    if (trig_ok) begin
      pend_valid_n = 1'b1;
      pend_addr_n  = tgt_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pend_valid       <= 1'b0;
      pend_addr        <= '0;
      addr_q           <= '0;
      line_data        <= '0;
      stale            <= 1'b0;
      prefetch_ready   <= 1'b0;
      prefetch_busy    <= 1'b0;
      prefetch_address <= '0;
      prefetch_rdata   <= '0;
      pf_pmem_read     <= 1'b0;
      pf_pmem_address  <= '0;
    end else begin
      state            <= state_n;
      pend_valid       <= pend_valid_n;
      pend_addr        <= pend_addr_n;
      addr_q           <= addr_n;
      line_data        <= line_data_n;
      stale            <= stale_n;
      prefetch_ready   <= (state_n == READY);
      prefetch_busy    <= (state_n == FETCH);
      prefetch_address <= addr_n;
      prefetch_rdata   <= line_data_n;
      pf_pmem_read     <= (state_n == FETCH);
      pf_pmem_address  <= addr_n;
    end
  end

endmodule
